// File: rtl/inject_scheduler.sv
// -----------------------------------------------------------------------------
// inject_scheduler
//
// Campaign controller for the ICAPE2 frame-write path. A go pulse starts a
// campaign that walks the 7-series frame address (FAR) from FAR_START to
// FAR_END inclusive. Each frame is launched with a one-cycle wr_start, the
// block then waits for wr_done (bounded by TIMEOUT_CYCLES) and idles for
// GAP_CYCLES before the next frame. abort ends a running campaign at once.
//
// Writer handshake: wr_start is a single-cycle pulse issued from ISSUE; the
// writer answers with a single-cycle wr_done. frameaddr is held stable from
// wr_start until the frame ends (wr_done or timeout). wr_done is only
// observed in WAIT and is ignored anywhere else.
//
// Optional build macro INJECT_STEP_MODE_EN: adds the step input. GAP then
// ignores GAP_CYCLES and waits for a step pulse (registered once, so step
// to wr_start takes two cycles). GAP is entered even when GAP_CYCLES = 0.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   go            single-cycle campaign start (accepted only in IDLE)
//   abort         single-cycle abort (ISSUE/WAIT/GAP only)
//   wr_done       single-cycle completion from the frame writer
//   step          (INJECT_STEP_MODE_EN only) advance out of GAP
//   wr_start      single-cycle start to the frame writer
//   frameaddr     FAR presented to the frame writer
//   busy          high from the cycle after go through the FINISH cycle
//   campaign_done single-cycle pulse when a campaign ends
//   timeout_err   sticky per-frame timeout flag, cleared by accepted go
//   frame_cnt     frames completed in the current or last campaign
//   dbg_state     current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module inject_scheduler #(
   parameter logic [31:0] FAR_START      = 32'h0000_0000,
   parameter logic [31:0] FAR_END        = 32'h0000_0023,
   parameter int          MINOR_MAX      = 36,
   parameter int          GAP_CYCLES     = 16,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic        abort,
   input  logic        wr_done,
`ifdef INJECT_STEP_MODE_EN
   input  logic        step,
`endif
   output logic        wr_start,
   output logic [31:0] frameaddr,
   output logic        busy,
   output logic        campaign_done,
   output logic        timeout_err,
   output logic [15:0] frame_cnt,
   output logic [2:0]  dbg_state
);

   // One counter serves both the WAIT timeout and the GAP length, so it is
   // sized for the larger of the two.
   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]    MINOR_LAST = 7'(MINOR_MAX - 1);

`ifdef INJECT_STEP_MODE_EN
   localparam bit ENTER_GAP = 1'b1;
`else
   localparam bit ENTER_GAP = (GAP_CYCLES != 0);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      GAP    = 3'd3,
      FINISH = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   far_q, far_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          terr_q, terr_d;

`ifdef INJECT_STEP_MODE_EN
   logic          step_q;
`endif

   // Minor field wraps at MINOR_MAX and carries into the 10-bit column;
   // column overflow wraps silently and FAR[31:17] is left untouched.
   function automatic logic [31:0] far_advance(input logic [31:0] far);
      logic [31:0] nxt;
      nxt = far;
      if (far[6:0] == MINOR_LAST) begin
         nxt[6:0]  = 7'd0;
         nxt[16:7] = far[16:7] + 10'd1;
      end else begin
         nxt[6:0]  = far[6:0] + 7'd1;
      end
      return nxt;
   endfunction

   always_comb begin
      state_d     = state_q;
      far_d       = far_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      terr_d      = terr_q;

      case (state_q)
         IDLE: begin
            if (go) begin
               far_d       = FAR_START;
               frame_cnt_d = 16'd0;
               terr_d      = 1'b0;
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d   = '0;
            state_d = abort ? FINISH : WAIT;
         end

         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (abort) begin
               state_d = FINISH;
            end else if (wr_done || (cnt_q == TO_LAST)) begin
               // A done in the timeout cycle wins: the frame counts, no error.
               if (wr_done) begin
                  if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  terr_d = 1'b1;
               end
               cnt_d = '0;
               if (far_q == FAR_END) begin
                  state_d = FINISH;
               end else begin
                  far_d   = far_advance(far_q);
                  state_d = ENTER_GAP ? GAP : ISSUE;
               end
            end
         end

         GAP: begin
            if (abort) begin
               state_d = FINISH;
            end else begin
`ifdef INJECT_STEP_MODE_EN
               if (step_q) state_d = ISSUE;
`else
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == GAP_LAST) state_d = ISSUE;
`endif
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         far_q       <= FAR_START;
         cnt_q       <= '0;
         frame_cnt_q <= 16'd0;
         terr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         far_q       <= far_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         terr_q      <= terr_d;
      end
   end

`ifdef INJECT_STEP_MODE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) step_q <= 1'b0;
      else        step_q <= step;
   end
`endif

   // Pulses are decodes of registered state, so they are glitch-free and an
   // abort arriving in ISSUE cannot suppress that cycle's wr_start.
   assign wr_start      = (state_q == ISSUE);
   assign campaign_done = (state_q == FINISH);
   assign busy          = (state_q != IDLE);
   assign frameaddr     = far_q;
   assign timeout_err   = terr_q;
   assign frame_cnt     = frame_cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: doc/inject_scheduler.md
Name: inject_scheduler

Overview:
- Campaign controller for the ICAPE2 frame-write path.
- On a `go` pulse it walks the 7-series frame address (FAR) from FAR_START to FAR_END, one frame at a time.
- For each frame it issues a one-cycle start to the frame writer, waits for that writer's completion flag, then idles a programmable gap before the next frame.
- It sits between the user trigger logic and the frame writer, replacing the free-running address generator with a bounded, timed, abortable sequence.

Parameters:
- FAR_START, 32'h0000_0000, first FAR issued.
- FAR_END, 32'h0000_0023, last FAR issued (inclusive).
- MINOR_MAX, 36, number of minor frames per column; minor field FAR[6:0] wraps at MINOR_MAX.
- GAP_CYCLES, 16, idle cycles between a done and the next start (0 allowed).
- TIMEOUT_CYCLES, 4096, maximum cycles waited for wr_done per frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- go  input  1  single-cycle campaign start request
- abort  input  1  single-cycle abort request
- wr_done  input  1  single-cycle completion pulse from frame writer
- wr_start  output  1  single-cycle start pulse to frame writer
- frameaddr  output  32  FAR presented to frame writer; stable from wr_start until wr_done
- busy  output  1  high while a campaign is running
- campaign_done  output  1  single-cycle pulse when the campaign ends normally or by abort
- timeout_err  output  1  sticky; set on any per-frame timeout, cleared by next accepted go
- frame_cnt  output  16  frames completed in the current or last campaign

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - state = IDLE; wr_start = 0; busy = 0; campaign_done = 0; timeout_err = 0; frame_cnt = 0.
  - frameaddr = FAR_START.
- All state is registered on the rising edge of clk.
- States: IDLE, ISSUE, WAIT, GAP, FINISH.
- IDLE:
  - go = 1 → frameaddr <= FAR_START, frame_cnt <= 0, timeout_err <= 0, busy <= 1, go to ISSUE.
  - go is ignored in every other state.
- ISSUE:
  - wr_start = 1 for exactly this one cycle.
  - Timeout counter cleared; next state WAIT.
  - Latency from go to wr_start is 1 cycle.
- WAIT:
  - Timeout counter increments each cycle.
  - wr_done = 1 → frame_cnt + 1 (saturates at 16'hFFFF).
    - If frameaddr == FAR_END → FINISH.
    - Otherwise advance the address and go to GAP, or straight to ISSUE when GAP_CYCLES = 0.
  - Counter reaches TIMEOUT_CYCLES with no wr_done → timeout_err <= 1. The frame is not counted; the address advances and the campaign continues exactly as for a done.
  - wr_done arriving in the same cycle the timeout is reached → treated as done; no error.
- Address advance rule:
  - If FAR[6:0] == MINOR_MAX-1: FAR[6:0] <= 0 and FAR[16:7] (column) <= column + 1.
  - Otherwise FAR[6:0] <= FAR[6:0] + 1.
  - Upper bits FAR[31:17] are never modified.
  - Column overflow (10'h3FF + 1) wraps to 0 silently.
- GAP: counts GAP_CYCLES cycles, then goes to ISSUE.
- FINISH:
  - campaign_done = 1 for one cycle; busy <= 0; next state IDLE.
  - frame_cnt holds its value until the next go.
- abort has priority over all other transitions in ISSUE, WAIT and GAP:
  - Next state FINISH; no further wr_start.
  - If abort coincides with ISSUE, that cycle's wr_start still fires (already registered).
  - abort in IDLE is ignored.
- wr_done outside WAIT is ignored.
- If FAR_END is not reachable from FAR_START via the advance rule, the campaign runs until abort. This is an integration error; the block does not check for it.
- busy is high from the cycle after go through the FINISH cycle.

Optional Feature:
- Macro: INJECT_STEP_MODE_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - The GAP state ignores GAP_CYCLES and waits for a step pulse before going to ISSUE.
  - If GAP_CYCLES = 0, GAP is still entered.
  - abort still exits GAP immediately.
- Not defined:
  - No `step` port.
  - GAP timing is exactly GAP_CYCLES as above.

Test Plan:
- Basic campaign: FAR_START = 0, FAR_END = 3, GAP_CYCLES = 2; go; writer answers wr_done 5 cycles after each wr_start.
  - Exactly 4 wr_start pulses with frameaddr 0, 1, 2, 3.
  - campaign_done pulse, frame_cnt = 4, busy low afterwards.
- Minor wrap: FAR_START = 32'h0000_0022, FAR_END = 32'h0000_0081, MINOR_MAX = 36.
  - Issued sequence 0x22, 0x23, 0x80, 0x81.
  - frame_cnt = 4.
- Timeout: TIMEOUT_CYCLES = 8; writer never answers the second frame of 3.
  - timeout_err set 8 cycles into that WAIT.
  - Third frame still issued; frame_cnt = 2.
  - Next go clears timeout_err.
- Abort mid-WAIT on frame 2 of 10.
  - No further wr_start; campaign_done 1 cycle after abort; frame_cnt = 1; busy = 0.
  - Late wr_done ignored.
- Reset during WAIT: assert rst_n low asynchronously.
  - All outputs at reset values immediately, without waiting for a clk edge.
  - After release, go restarts from FAR_START.
- Step mode (INJECT_STEP_MODE_EN defined), FAR_END = FAR_START + 1.
  - After first wr_done, no wr_start for 100 cycles.
  - A step pulse produces wr_start 2 cycles later.
